rn_ds_pipe: RTL and testbench

Parametrised rename→dispatch pipeline stage carrying a group of up to LANES renamed instructions plus the group PC from rename to dispatch. It adds per-lane valid bits, a valid/ready handshake with back-pressure, and synchronous flush. An optional skid slot registers `up_ready`. Empty groups are dropped so that no bubbles reach dispatch.

---
 rtl/rn_ds_pkg.sv | 48 ++++
 rtl/rn_ds_slot.sv | 46 ++++
 rtl/rn_ds_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_rn_ds_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rn_ds_pkg.sv
// Shared types and helpers for the rename->dispatch pipeline stage.
// Latency: n/a (types, constants and functions only).
// Backpressure: n/a.
//
// Contents: lane field widths/offsets for the default configuration, the
// packed-lane width derivation, the stage state enum and a popcount helper.
package rn_ds_pkg;

    // Default lane field widths.
    localparam int ALUOP_W_DEF = 9;
    localparam int AREG_W_DEF  = 5;
    localparam int PREG_W_DEF  = 6;
    localparam int IMM_W_DEF   = 32;

    // Field offsets inside a lane for the default widths.
    // Packing MSB->LSB: ALUop, Src1, Src2, Rdst, RSrc1, RSrc2, Phydst, imm.
    localparam int OFF_IMM    = 0;
    localparam int OFF_PHYDST = OFF_IMM    + IMM_W_DEF;
    localparam int OFF_RSRC2  = OFF_PHYDST + PREG_W_DEF;
    localparam int OFF_RSRC1  = OFF_RSRC2  + PREG_W_DEF;
    localparam int OFF_RDST   = OFF_RSRC1  + PREG_W_DEF;
    localparam int OFF_SRC2   = OFF_RDST   + AREG_W_DEF;
    localparam int OFF_SRC1   = OFF_SRC2   + AREG_W_DEF;
    localparam int OFF_ALUOP  = OFF_SRC1   + AREG_W_DEF;

    // Width of one packed lane for arbitrary field widths.
    function automatic int lane_w(input int aluop_w, input int areg_w,
                                  input int preg_w, input int imm_w);
        return aluop_w + 3 * areg_w + 3 * preg_w + imm_w;
    endfunction

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } ds_state_e;

    // Population count of up to 8 lane-valid bits (LANES is at most 8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rn_ds_slot.sv
// One register slot of the rename->dispatch stage: pc, lane valids, lanes, count.
// Latency: 1 cycle from load to q_*.
// Backpressure: none; the parent decides when to load or clear.
//
// Ports: clk, rst_n (async active-low), load, clear (clear wins over load),
// d_* data in, q_* registered data out.
module rn_ds_slot #(
    parameter int PC_W   = 32,
    parameter int LANES  = 4,
    parameter int LANE_W = 74,
    parameter int CNT_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    clear,
    input  logic [PC_W-1:0]         d_pc,
    input  logic [LANES-1:0]        d_lane_vld,
    input  logic [LANES*LANE_W-1:0] d_lane,
    input  logic [CNT_W-1:0]        d_cnt,
    output logic [PC_W-1:0]         q_pc,
    output logic [LANES-1:0]        q_lane_vld,
    output logic [LANES*LANE_W-1:0] q_lane,
    output logic [CNT_W-1:0]        q_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pc       <= '0;
            q_lane_vld <= '0;
            q_lane     <= '0;
            q_cnt      <= '0;
        end else if (clear) begin
            q_pc       <= '0;
            q_lane_vld <= '0;
            q_lane     <= '0;
            q_cnt      <= '0;
        end else if (load) begin
            q_pc       <= d_pc;
            q_lane_vld <= d_lane_vld;
            q_lane     <= d_lane;
            q_cnt      <= d_cnt;
        end
    end

endmodule

// File: rtl/rn_ds_pipe.sv
// Rename->dispatch pipeline stage for a group of LANES instructions plus PC.
// Latency: 1 cycle (accept at edge N, dn_valid at N+1); empty groups are dropped.
// Backpressure: valid/ready; with RN_DS_SKID_EN a skid slot makes up_ready a
//   registered function of state, otherwise up_ready = !dn_valid | dn_ready.
//
// Optional feature macro: RN_DS_SKID_EN (adds skid slot and SKID state).
// Ports: clk, rst_n (async active-low), flush (sync, highest priority),
//   up_valid/up_ready/up_pc/up_lane_vld/up_lane from rename,
//   dn_valid/dn_ready/dn_pc/dn_lane_vld/dn_lane/dn_cnt to dispatch.
module rn_ds_pipe
    import rn_ds_pkg::*;
#(
    parameter  int LANES   = 4,
    parameter  int PC_W    = 32,
    parameter  int ALUOP_W = 9,
    parameter  int AREG_W  = 5,
    parameter  int PREG_W  = 6,
    parameter  int IMM_W   = 32,
    localparam int LANE_W  = lane_w(ALUOP_W, AREG_W, PREG_W, IMM_W),
    localparam int CNT_W   = $clog2(LANES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [PC_W-1:0]         up_pc,
    input  logic [LANES-1:0]        up_lane_vld,
    input  logic [LANES*LANE_W-1:0] up_lane,
    output logic                    dn_valid,
    input  logic                    dn_ready,
    output logic [PC_W-1:0]         dn_pc,
    output logic [LANES-1:0]        dn_lane_vld,
    output logic [LANES*LANE_W-1:0] dn_lane,
    output logic [CNT_W-1:0]        dn_cnt
);

    ds_state_e state, state_nxt;

    logic                    acc_ne;
    logic                    dlv;
    logic [CNT_W-1:0]        up_cnt;
    logic                    main_load;
    logic                    main_clear;
    logic [PC_W-1:0]         main_pc_d;
    logic [LANES-1:0]        main_vld_d;
    logic [LANES*LANE_W-1:0] main_lane_d;
    logic [CNT_W-1:0]        main_cnt_d;

    // Only non-empty groups occupy a slot; empty ones are consumed silently.
    assign acc_ne = up_valid & up_ready & (|up_lane_vld);
    assign dlv    = dn_valid & dn_ready;
    assign up_cnt = CNT_W'(popcount8(8'(up_lane_vld)));

`ifdef RN_DS_SKID_EN
    logic                    skid_load;
    logic                    skid_clear;
    logic                    main_from_skid;
    logic [PC_W-1:0]         skid_pc;
    logic [LANES-1:0]        skid_lane_vld;
    logic [LANES*LANE_W-1:0] skid_lane;
    logic [CNT_W-1:0]        skid_cnt;

    assign main_pc_d   = main_from_skid ? skid_pc       : up_pc;
    assign main_vld_d  = main_from_skid ? skid_lane_vld : up_lane_vld;
    assign main_lane_d = main_from_skid ? skid_lane     : up_lane;
    assign main_cnt_d  = main_from_skid ? skid_cnt      : up_cnt;

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_nxt  = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc_ne) begin
                        main_load = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (acc_ne && dlv) begin
                        main_load = 1'b1;
                    end else if (acc_ne) begin
                        skid_load = 1'b1;
                        state_nxt = SKID;
                    end else if (dlv) begin
                        main_clear = 1'b1;
                        state_nxt  = EMPTY;
                    end
                end
                SKID: begin
                    // up_ready is low here, so only a delivery can move us.
                    if (dlv) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_nxt      = FULL;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    rn_ds_slot #(
        .PC_W   (PC_W),
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .CNT_W  (CNT_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .clear      (skid_clear),
        .d_pc       (up_pc),
        .d_lane_vld (up_lane_vld),
        .d_lane     (up_lane),
        .d_cnt      (up_cnt),
        .q_pc       (skid_pc),
        .q_lane_vld (skid_lane_vld),
        .q_lane     (skid_lane),
        .q_cnt      (skid_cnt)
    );

    // up_ready is precomputed from next state so it has no comb input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_ready <= 1'b1;
        end else begin
            up_ready <= (state_nxt != SKID);
        end
    end
`else
    assign main_pc_d   = up_pc;
    assign main_vld_d  = up_lane_vld;
    assign main_lane_d = up_lane;
    assign main_cnt_d  = up_cnt;

    assign up_ready = !dn_valid | dn_ready;

    always_comb begin
        state_nxt  = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            state_nxt  = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc_ne) begin
                        main_load = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    // Acceptance while FULL implies dn_ready, so reload in place.
                    if (acc_ne) begin
                        main_load = 1'b1;
                    end else if (dlv) begin
                        main_clear = 1'b1;
                        state_nxt  = EMPTY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end
`endif

    rn_ds_slot #(
        .PC_W   (PC_W),
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .CNT_W  (CNT_W)
    ) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (main_load),
        .clear      (main_clear),
        .d_pc       (main_pc_d),
        .d_lane_vld (main_vld_d),
        .d_lane     (main_lane_d),
        .d_cnt      (main_cnt_d),
        .q_pc       (dn_pc),
        .q_lane_vld (dn_lane_vld),
        .q_lane     (dn_lane),
        .q_cnt      (dn_cnt)
    );

    // dn_valid is its own flop so dispatch sees a pure register output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            dn_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            dn_valid <= (state_nxt != EMPTY);
        end
    end

endmodule

// File: tb/tb_rn_ds_pipe.sv
// Directed self-checking bench for rn_ds_pipe (default parameters).
// Latency: expects accepted groups on dn_* one cycle after the accepting edge.
// Backpressure: drives dn_ready low/high and follows up_ready when offering.
module tb_rn_ds_pipe;

    localparam int LW = 74;
    localparam int NL = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             up_valid;
    logic             up_ready;
    logic [31:0]      up_pc;
    logic [NL-1:0]    up_lane_vld;
    logic [NL*LW-1:0] up_lane;
    logic             dn_valid;
    logic             dn_ready;
    logic [31:0]      dn_pc;
    logic [NL-1:0]    dn_lane_vld;
    logic [NL*LW-1:0] dn_lane;
    logic [2:0]       dn_cnt;

    int checks = 0;
    int errors = 0;

    // Handshake/outputs sampled at the falling edge preceding each rising edge.
    logic        acc_s;
    logic        dlv_s;
    logic [31:0] pc_s;
    logic [2:0]  cnt_s;

    // Groups used by the back-pressure and flush scenarios.
    logic [31:0] g_pc  [3] = '{32'h0000_0A00, 32'h0000_0B00, 32'h0000_0C00};
    logic [3:0]  g_lv  [3] = '{4'b1111, 4'b0110, 4'b1000};
    logic [2:0]  g_cnt [3] = '{3'd4, 3'd2, 3'd1};

    rn_ds_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_pc       (up_pc),
        .up_lane_vld (up_lane_vld),
        .up_lane     (up_lane),
        .dn_valid    (dn_valid),
        .dn_ready    (dn_ready),
        .dn_pc       (dn_pc),
        .dn_lane_vld (dn_lane_vld),
        .dn_lane     (dn_lane),
        .dn_cnt      (dn_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] lane_val(input int g, input int k);
        return {10'(k), 32'(g * 32'h0101_0101) ^ 32'hDEAD_0000, 32'(g + k * 7)};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [3:0] lv, input int g);
        up_valid    = 1'b1;
        up_pc       = pc;
        up_lane_vld = lv;
        for (int k = 0; k < NL; k++) begin
            up_lane[k*LW +: LW] = lane_val(g, k);
        end
    endtask

    // Advance one clock; leaves time at rising edge + 1.
    task automatic tick();
        @(negedge clk);
        acc_s = up_valid & up_ready;
        dlv_s = dn_valid & dn_ready;
        pc_s  = dn_pc;
        cnt_s = dn_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
        up_pc = '0; up_lane_vld = '0; up_lane = '0;
        #12;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL rst_dn_valid got %b exp 0", dn_valid); end
        checks++; if (dn_pc !== 32'h0) begin errors++; $display("FAIL rst_dn_pc got %h exp 0", dn_pc); end
        checks++; if (dn_lane_vld !== 4'h0) begin errors++; $display("FAIL rst_dn_lane_vld got %b exp 0", dn_lane_vld); end
        checks++; if (dn_lane !== '0) begin errors++; $display("FAIL rst_dn_lane got %h exp 0", dn_lane); end
        checks++; if (dn_cnt !== 3'd0) begin errors++; $display("FAIL rst_dn_cnt got %0d exp 0", dn_cnt); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL rst_up_ready got %b exp 1", up_ready); end
    endtask

    task automatic test_basic();
        dn_ready = 1'b1;
        drive(32'h100, 4'b1011, 1);
        tick();
        up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", dn_valid); end
        checks++; if (dn_pc !== 32'h100) begin errors++; $display("FAIL basic_pc got %h exp 100", dn_pc); end
        checks++; if (dn_cnt !== 3'd3) begin errors++; $display("FAIL basic_cnt got %0d exp 3", dn_cnt); end
        checks++; if (dn_lane_vld !== 4'b1011) begin errors++; $display("FAIL basic_lane_vld got %b exp 1011", dn_lane_vld); end
        checks++; if (dn_lane[LW-1:0] !== lane_val(1, 0)) begin errors++; $display("FAIL basic_lane0 got %h exp %h", dn_lane[LW-1:0], lane_val(1, 0)); end
        tick();
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", dn_valid); end
    endtask

    task automatic test_empty_group();
        dn_ready = 1'b1;
        drive(32'h180, 4'b0000, 2);
        #1;
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL empty_up_ready got %b exp 1", up_ready); end
        tick();
        checks++; if (acc_s !== 1'b1) begin errors++; $display("FAIL empty_consumed got %b exp 1", acc_s); end
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL empty_dn_valid got %b exp 0", dn_valid); end
        drive(32'h200, 4'b0001, 3);
        tick();
        up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b1) begin errors++; $display("FAIL empty_next_valid got %b exp 1", dn_valid); end
        checks++; if (dn_pc !== 32'h200) begin errors++; $display("FAIL empty_next_pc got %h exp 200", dn_pc); end
        checks++; if (dn_cnt !== 3'd1) begin errors++; $display("FAIL empty_next_cnt got %0d exp 1", dn_cnt); end
        tick();
    endtask

    task automatic test_back_to_back_pressure();
        int oi;
        int di;
        oi = 0;
        di = 0;
        dn_ready = 1'b0;
        drive(g_pc[0], g_lv[0], 20);
        repeat (3) begin
            tick();
            if (acc_s) oi++;
            if (oi < 3) drive(g_pc[oi], g_lv[oi], 20 + oi);
            else up_valid = 1'b0;
        end
        checks++; if (dn_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b exp 1", dn_valid); end
        checks++; if (dn_pc !== g_pc[0]) begin errors++; $display("FAIL bp_hold_pc got %h exp %h", dn_pc, g_pc[0]); end
        checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL bp_up_ready got %b exp 0", up_ready); end
`ifdef RN_DS_SKID_EN
        checks++; if (oi !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", oi); end
`else
        checks++; if (oi !== 1) begin errors++; $display("FAIL bp_accepted got %0d exp 1", oi); end
`endif
        dn_ready = 1'b1;
        for (int c = 0; c < 12 && di < 3; c++) begin
            tick();
            if (acc_s) begin
                oi++;
                if (oi < 3) drive(g_pc[oi], g_lv[oi], 20 + oi);
                else up_valid = 1'b0;
            end
            if (dlv_s) begin
                checks++; if (pc_s !== g_pc[di]) begin errors++; $display("FAIL bp_order_pc[%0d] got %h exp %h", di, pc_s, g_pc[di]); end
                checks++; if (cnt_s !== g_cnt[di]) begin errors++; $display("FAIL bp_order_cnt[%0d] got %0d exp %0d", di, cnt_s, g_cnt[di]); end
                di++;
            end
        end
        up_valid = 1'b0;
        checks++; if (di !== 3) begin errors++; $display("FAIL bp_delivered got %0d exp 3", di); end
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", dn_valid); end
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        dn_ready = 1'b0;
        drive(g_pc[0], g_lv[0], 30);
        tick();
        drive(g_pc[1], g_lv[1], 31);
        tick();
        drive(g_pc[2], g_lv[2], 32);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", dn_valid); end
        checks++; if (dn_lane_vld !== 4'h0) begin errors++; $display("FAIL flush_lane_vld got %b exp 0", dn_lane_vld); end
        checks++; if (dn_cnt !== 3'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", dn_cnt); end
        checks++; if (dn_pc !== 32'h0) begin errors++; $display("FAIL flush_pc got %h exp 0", dn_pc); end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL flush_up_ready got %b exp 1", up_ready); end
        dn_ready = 1'b1;
        repeat (3) begin
            tick();
            if (dlv_s) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_leak got %0d exp 0", seen); end
        // Flush beats an accept offered while the stage is ready.
        drive(32'h0000_0D00, 4'b0011, 33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL flush_prio got %b exp 0", dn_valid); end
    endtask

    task automatic test_stream();
        logic [3:0]       lv;
        logic [NL*LW-1:0] exp_lane;
        dn_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lv = 4'((i % 15) + 1);
            drive(32'h1000 + 32'(i), lv, 40 + i);
            tick();
            for (int k = 0; k < NL; k++) exp_lane[k*LW +: LW] = lane_val(40 + i, k);
            checks++; if (acc_s !== 1'b1) begin errors++; $display("FAIL stream_acc[%0d] got %b exp 1", i, acc_s); end
            checks++; if (dn_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, dn_valid); end
            checks++; if (dn_pc !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, dn_pc, 32'h1000 + 32'(i)); end
            checks++; if (dn_cnt !== 3'($countones(lv))) begin errors++; $display("FAIL stream_cnt[%0d] got %0d exp %0d", i, dn_cnt, $countones(lv)); end
            checks++; if (dn_lane !== exp_lane) begin errors++; $display("FAIL stream_lane[%0d] got %h exp %h", i, dn_lane, exp_lane); end
        end
        up_valid = 1'b0;
        tick();
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", dn_valid); end
    endtask

    task automatic test_async_reset();
        dn_ready = 1'b0;
        drive(32'h0000_0E00, 4'b0101, 60);
        tick();
        up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %b exp 1", dn_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", dn_valid); end
        checks++; if (dn_pc !== 32'h0) begin errors++; $display("FAIL arst_pc got %h exp 0", dn_pc); end
        checks++; if (dn_cnt !== 3'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", dn_cnt); end
        #2;
        rst_n = 1'b1;
        tick();
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL arst_post_valid got %b exp 0", dn_valid); end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL arst_post_ready got %b exp 1", up_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_group();
        test_back_to_back_pressure();
        test_flush();
        test_stream();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
